bus_server: RTL and testbench
=============================

# bus_server

Bus responder that terminates the four-phase `rq`/`ack` handshake driven by bus clients (via the arbiter's muxed bus). Owns a small register-file window `[ADDR_SPACE_BEGINNING, ADDR_SPACE_END]` and performs reads and writes there. Inserts a programmable number of wait states before acknowledging. Several instances with disjoint windows share one bus; each ignores requests outside its window.

## Interface
- `DATA_WIDTH`, 8: data bus width.
- `ADDR_WIDTH`, 4: address bus width.
- `ADDR_SPACE_BEGINNING`, 0: lowest address owned (inclusive).
- `ADDR_SPACE_END`, 3: highest address owned (inclusive); `DEPTH = END - BEGINNING + 1` entries.
- `ACK_DELAY`, 2: wait states between request capture and `ack` (0..255).

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (active 0).
- `address`  in  ADDR_WIDTH  transaction address.
- `rq`  in  1  request from the granted client.
- `wr_ni`  in  1  1 = read, 0 = write.
- `dataW`  in  DATA_WIDTH  write data.
- `ack`  out  1  acknowledge, registered.
- `dataR`  out  DATA_WIDTH  read data, registered.
- `rd_count`, `wr_count`  out  16 each  completed-transaction counters (only with `BUS_SERVER_STATS_EN`).

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: on `rq`=1 with `address` in the window:
  - capture `address`, `wr_ni`, and `dataW`.
  - load the wait counter with `ACK_DELAY`.
  - go to WAIT, or go directly to ACK if `ACK_DELAY`=0.
  - `rq`=1 with `address` outside the window: stay IDLE, no side effects.
- WAIT: decrement the counter each cycle. Go to ACK on the edge where the counter is 1.
  - `rq` sampled 0 in WAIT: abort. Return to IDLE with no write, no `dataR` update, no `ack`.
- Entry to ACK (same edge that raises `ack`):
  - write: `mem[idx] <= dataW_captured`.
  - read: `dataR <= mem[idx]`.
  - `idx = address_captured - ADDR_SPACE_BEGINNING`.
- ACK: hold `ack`=1 until `rq` is sampled 0, then return to IDLE with `ack`=0.
- `dataR` holds its last value outside ACK. Writes do not change `dataR`.
- Only captured values are used: changes on `address`, `wr_ni`, or `dataW` after capture have no effect.
- Reset (any time, including mid-transaction):
  - `ack`=0, `dataR`=0, all `mem` entries 0, state IDLE, counter 0, stats counters 0.
  - After reset release, an in-progress `rq` is treated as a new request.

## Timing
- `rq` sampled high at edge k (IDLE) → `ack` high after edge k+`ACK_DELAY`. With `ACK_DELAY`=0, `ack` is high after edge k.
- Read data is valid on `dataR` in the same cycle `ack` first reads 1.
- `rq` sampled low at edge m (ACK) → `ack` low after edge m.
- The next request can be captured at edge m+1.
- Client round trip (client drops `rq` one cycle after seeing `ack`): `ack` is high for 2 cycles.
- Window check: `address >= BEGINNING && address <= END`, compared unsigned at ADDR_WIDTH.

## Configuration
- `BUS_SERVER_STATS_EN` defined:
  - `rd_count`/`wr_count` ports exist.
  - Each counter increments by 1 on ACK entry for its transaction type.
  - Counters wrap 0xFFFF→0. Aborted transactions do not count.
- Undefined: ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=0 with `rq`=1 → `ack`=0, `dataR`=0x00. After release, a read of address 0 returns 0x00.
- Write then read, `ACK_DELAY`=2:
  - write 0x04 to address 2 → `ack` rises 2 edges after capture.
  - read address 2 → `dataR`=0x04 in the first `ack` cycle.
  - with stats: `wr_count`=1, `rd_count`=1.
- Out of window: `rq`=1, `address`=5 (window 0..3) for 20 cycles → `ack` stays 0, memory unchanged.
- Abort: write 0xAA to address 1, drop `rq` during WAIT → no `ack`. A later read of address 1 returns the previous value.
- `ACK_DELAY`=0: back-to-back writes to addresses 0..3, with the client re-raising `rq` the cycle after `ack` drops → each `ack` rises the cycle after capture, and all four values read back correctly.
- Mid-ACK reset: assert `reset`=0 while `ack`=1 → `ack` drops asynchronously, all memory entries read 0 afterward.

Source files
------------

// File: rtl/bus_server_if.sv
// bus_server_if: muxed client bus carrying the four-phase rq/ack handshake,
// address, direction and data between the granted client and the responders.
interface bus_server_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  rq;
   logic                  wr_ni;
   logic [DATA_WIDTH-1:0] dataW;
   logic                  ack;
   logic [DATA_WIDTH-1:0] dataR;

   modport master (
      output address, rq, wr_ni, dataW,
      input  ack, dataR
   );

   modport slave (
      input  address, rq, wr_ni, dataW,
      output ack, dataR
   );
endinterface

// File: rtl/bus_server.sv
// bus_server: four-phase rq/ack responder owning the register window [BEGINNING, END],
// with ACK_DELAY wait states. Define BUS_SERVER_STATS_EN for rd_count/wr_count.
module bus_server #(
   parameter int DATA_WIDTH           = 8,
   parameter int ADDR_WIDTH           = 4,
   parameter int ADDR_SPACE_BEGINNING = 0,
   parameter int ADDR_SPACE_END       = 3,
   parameter int ACK_DELAY            = 2
) (
   input  logic        clk,
   input  logic        reset,
   bus_server_if.slave bus
`ifdef BUS_SERVER_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
   localparam logic [ADDR_WIDTH-1:0] SPAN_C  = ADDR_WIDTH'(ADDR_SPACE_END - ADDR_SPACE_BEGINNING);
   localparam logic [7:0]            DELAY_C = 8'(ACK_DELAY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q;
   logic                  wr_ni_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] dataR_q;

   logic [ADDR_WIDTH-1:0] off_s;
   logic                  in_win_s;
   logic                  cap_s;
   logic                  access_s;
   logic [IDX_W-1:0]      acc_idx_s;
   logic                  acc_rd_s;
   logic [DATA_WIDTH-1:0] acc_data_s;

   // Modular offset compare: in window iff (address - BEGINNING) wraps to at most END - BEGINNING.
   assign off_s    = bus.address - BASE_C;
   assign in_win_s = (off_s <= SPAN_C);

   assign bus.ack   = ack_q;
   assign bus.dataR = dataR_q;

   // Next-state, wait counter and access strobe.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_s    = 1'b0;
      access_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rq && in_win_s) begin
               cap_s = 1'b1;
               cnt_d = DELAY_C;
               if (DELAY_C == 8'd0) begin
                  state_d  = ACK;
                  access_s = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (!bus.rq) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q <= 8'd1) begin
               state_d  = ACK;
               cnt_d    = 8'd0;
               access_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACK: begin
            if (!bus.rq) begin
               state_d = IDLE;
            end else begin
               state_d = ACK;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // With zero wait states the access happens on the capture edge, so live inputs feed it.
   always_comb begin
      if (state_q == IDLE) begin
         acc_idx_s  = off_s[IDX_W-1:0];
         acc_rd_s   = bus.wr_ni;
         acc_data_s = bus.dataW;
      end else begin
         acc_idx_s  = idx_q;
         acc_rd_s   = wr_ni_q;
         acc_data_s = data_q;
      end
   end

   // Control state, captured request and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         wr_ni_q <= 1'b0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         dataR_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= (state_d == ACK);
         if (cap_s) begin
            idx_q   <= off_s[IDX_W-1:0];
            wr_ni_q <= bus.wr_ni;
            data_q  <= bus.dataW;
         end
         if (access_s && acc_rd_s) begin
            dataR_q <= mem_q[acc_idx_s];
         end
      end
   end

   // Register file storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (access_s && !acc_rd_s) begin
         mem_q[acc_idx_s] <= acc_data_s;
      end
   end

`ifdef BUS_SERVER_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   // Completed-transaction counters; aborted requests never reach the access strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else if (access_s) begin
         if (acc_rd_s) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end else begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_bus_server.sv
// tb_bus_server: randomized self-checking bench for two responders (ACK_DELAY 2 and 0)
// against a behavioural model of memory contents, latency and last read data.
module tb_bus_server;

   logic clk;
   logic reset;

   bus_server_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
   bus_server_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if2 ();

`ifdef BUS_SERVER_STATS_EN
   logic [15:0] rd_cnt0, wr_cnt0, rd_cnt2, wr_cnt2;
`endif

   bus_server #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(0),
                .ADDR_SPACE_END(3), .ACK_DELAY(0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave)
`ifdef BUS_SERVER_STATS_EN
      , .rd_count(rd_cnt0), .wr_count(wr_cnt0)
`endif
   );

   bus_server #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(0),
                .ADDR_SPACE_END(3), .ACK_DELAY(2)) dut2 (
      .clk(clk), .reset(reset), .bus(if2.slave)
`ifdef BUS_SERVER_STATS_EN
      , .rd_count(rd_cnt2), .wr_count(wr_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: index 0 is the zero-delay server, index 1 the two-delay server.
   logic [7:0] m_mem [2][4];
   logic [7:0] m_last_rd [2];
   int         m_rd [2];
   int         m_wr [2];
   int         m_lat [2] = '{1, 3};

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 4; a++) m_mem[s][a] = 8'h00;
         m_last_rd[s] = 8'h00;
         m_rd[s] = 0;
         m_wr[s] = 0;
      end
   endtask

   task automatic drive(input int sel, input logic rq, input logic [3:0] a,
                        input logic rd, input logic [7:0] d);
      if (sel == 0) begin
         if0.rq = rq; if0.address = a; if0.wr_ni = rd; if0.dataW = d;
      end else begin
         if2.rq = rq; if2.address = a; if2.wr_ni = rd; if2.dataW = d;
      end
   endtask

   function automatic logic get_ack(input int sel);
      return (sel == 0) ? if0.ack : if2.ack;
   endfunction

   function automatic logic [7:0] get_data(input int sel);
      return (sel == 0) ? if0.dataR : if2.dataR;
   endfunction

   // One full handshake, entered and left at a negedge; client drops rq on seeing ack.
   task automatic xact(input int sel, input logic [3:0] a, input logic rd,
                       input logic [7:0] d, input string tag);
      int cyc = 0;
      drive(sel, 1'b1, a, rd, d);
      while (!get_ack(sel) && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      n_checks++;
      if (cyc !== m_lat[sel]) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges, expected %0d", tag, cyc, m_lat[sel]);
      end
      if (rd) m_last_rd[sel] = m_mem[sel][a];
      else begin
         m_mem[sel][a] = d;
      end
      if (rd) m_rd[sel]++; else m_wr[sel]++;
      n_checks++;
      if (get_data(sel) !== m_last_rd[sel]) begin
         n_fail++;
         $display("FAIL %s dataR: got %02h expected %02h", tag, get_data(sel), m_last_rd[sel]);
      end
      drive(sel, 1'b0, a, rd, d);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (get_ack(sel) !== 1'b0) begin
         n_fail++;
         $display("FAIL %s ack_drop: got %b expected 0", tag, get_ack(sel));
      end
   endtask

   task automatic check_all(input int sel, input string tag);
      for (int a = 0; a < 4; a++) xact(sel, 4'(a), 1'b1, 8'h00, tag);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 1'b0, 4'd0, 1'b1, 8'h00);
      drive(1, 1'b1, 4'd0, 1'b1, 8'h00);
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (if2.ack !== 1'b0 || if0.ack !== 1'b0 || if2.dataR !== 8'h00 || if0.dataR !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack %b/%b dataR %02h/%02h expected 0", if0.ack, if2.ack,
                  if0.dataR, if2.dataR);
      end
      reset = 1'b1;
      xact(1, 4'd0, 1'b1, 8'h00, "reset_rq_held");
   endtask

   task automatic test_write_read();
      xact(1, 4'd2, 1'b0, 8'h04, "wr_a2");
      xact(1, 4'd2, 1'b1, 8'h00, "rd_a2");
`ifdef BUS_SERVER_STATS_EN
      n_checks++;
      if (wr_cnt2 !== 16'(m_wr[1]) || rd_cnt2 !== 16'(m_rd[1])) begin
         n_fail++;
         $display("FAIL stats_wr_rd: got wr %0d rd %0d expected wr %0d rd %0d", wr_cnt2, rd_cnt2,
                  m_wr[1], m_rd[1]);
      end
`endif
      for (int i = 0; i < 16; i++) begin
         int s = $urandom_range(0, 1);
         xact(s, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), "random");
      end
   endtask

   task automatic test_out_of_window();
      int bad = 0;
      drive(1, 1'b1, 4'd5, 1'b0, 8'h5A);
      drive(0, 1'b1, 4'($urandom_range(4, 15)), 1'b0, 8'hA5);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (if2.ack !== 1'b0 || if0.ack !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL out_of_window ack: got %0d high cycles expected 0", bad);
      end
      drive(1, 1'b0, 4'd5, 1'b0, 8'h5A);
      drive(0, 1'b0, 4'd5, 1'b0, 8'hA5);
      @(negedge clk);
      check_all(1, "oow_mem2");
      check_all(0, "oow_mem0");
   endtask

   task automatic test_abort();
      int bad = 0;
      xact(1, 4'd1, 1'b0, 8'h3C, "abort_pre");
      drive(1, 1'b1, 4'd1, 1'b0, 8'hAA);
      @(posedge clk); @(negedge clk);
      drive(1, 1'b0, 4'd1, 1'b0, 8'hAA);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         if (if2.ack !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL abort_ack: got %0d high cycles expected 0", bad);
      end
      xact(1, 4'd1, 1'b1, 8'h00, "abort_readback");
   endtask

   task automatic test_captured();
      logic [7:0] d = 8'($urandom);
      int cyc = 0;
      drive(1, 1'b1, 4'd3, 1'b0, d);
      @(posedge clk); @(negedge clk);
      drive(1, 1'b1, 4'd0, 1'b1, ~d);
      while (!if2.ack && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      m_mem[1][3] = d;
      n_checks++;
      if (cyc !== 2 || if2.dataR !== m_last_rd[1]) begin
         n_fail++;
         $display("FAIL captured: got %0d edges dataR %02h expected 2 edges dataR %02h", cyc,
                  if2.dataR, m_last_rd[1]);
      end
      drive(1, 1'b0, 4'd0, 1'b1, ~d);
      @(posedge clk); @(negedge clk);
      check_all(1, "captured_mem");
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) xact(0, 4'(a), 1'b0, 8'($urandom), "b2b_wr");
      check_all(0, "b2b_rd");
   endtask

   task automatic test_round_trip();
      int hi = 0;
      int cyc = 0;
      drive(1, 1'b1, 4'd2, 1'b1, 8'h00);
      while (!if2.ack && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      m_last_rd[1] = m_mem[1][2];
      m_rd[1]++;
      for (int i = 0; i < 4; i++) begin
         if (if2.ack) hi++;
         if (i == 1) drive(1, 1'b0, 4'd2, 1'b1, 8'h00);
         @(posedge clk); @(negedge clk);
      end
      n_checks++;
      if (hi !== 2 || if2.dataR !== m_last_rd[1]) begin
         n_fail++;
         $display("FAIL round_trip: got %0d ack cycles dataR %02h expected 2 cycles dataR %02h",
                  hi, if2.dataR, m_last_rd[1]);
      end
   endtask

   task automatic test_mid_ack_reset();
      int cyc = 0;
      drive(1, 1'b1, 4'($urandom_range(0, 3)), 1'b1, 8'h00);
      while (!if2.ack && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (if2.ack !== 1'b0 || if2.dataR !== 8'h00 || cyc >= 50) begin
         n_fail++;
         $display("FAIL mid_ack_reset: got ack %b dataR %02h wait %0d expected ack 0 dataR 00",
                  if2.ack, if2.dataR, cyc);
      end
      @(negedge clk);
      drive(1, 1'b0, 4'd0, 1'b1, 8'h00);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      check_all(1, "post_reset_mem2");
      check_all(0, "post_reset_mem0");
   endtask

   initial begin
      drive(0, 1'b0, 4'd0, 1'b1, 8'h00);
      drive(1, 1'b0, 4'd0, 1'b1, 8'h00);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_out_of_window();
      test_abort();
      test_captured();
      test_back_to_back();
      test_round_trip();
      test_mid_ack_reset();
`ifdef BUS_SERVER_STATS_EN
      n_checks++;
      if (rd_cnt0 !== 16'(m_rd[0]) || wr_cnt0 !== 16'(m_wr[0]) ||
          rd_cnt2 !== 16'(m_rd[1]) || wr_cnt2 !== 16'(m_wr[1])) begin
         n_fail++;
         $display("FAIL stats_final: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", rd_cnt0,
                  wr_cnt0, rd_cnt2, wr_cnt2, m_rd[0], m_wr[0], m_rd[1], m_wr[1]);
      end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
